// File: rtl/branch_resolve_queue_pkg.sv
// rtl/branch_resolve_queue_pkg.sv - shared widths and helpers for the branch resolve queue
package branch_resolve_queue_pkg;
  localparam int GHR_LEN   = 8;
  localparam int PHT_NUMS  = 1 << GHR_LEN;
  localparam int BRQ_DEPTH = 4;
  localparam int PC_W_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef logic [$clog2(PHT_NUMS)-1:0] pht_idx_t;

  // Entry layout is {index, pred, alt_pc}.
  function automatic int entry_width(input int idx_w, input int pc_w);
    return idx_w + 1 + pc_w;
  endfunction

  // Mispredict flag plus redirect PC travel together.
  function automatic int redirect_width(input int pc_w);
    return 1 + pc_w;
  endfunction
endpackage

// File: rtl/brq_ring.sv
// rtl/brq_ring.sv - circular entry store with push/pop/clear for the branch resolve queue
module brq_ring
  import branch_resolve_queue_pkg::*;
#(
  parameter int IDX_W = $bits(pht_idx_t),
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = BRQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_B = PTR_W + 1,
  localparam int ENT_W = entry_width(IDX_W, PC_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_index,
  input  logic             push_pred,
  input  logic [PC_W-1:0]  push_alt_pc,
  input  logic             pop,
  input  logic             clear,
  output logic [IDX_W-1:0] head_index,
  output logic             head_pred,
  output logic [PC_W-1:0]  head_alt_pc,
  output logic [CNT_B-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Clear wins over push/pop: a squash drops the same-cycle alloc too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_B'(1);
        2'b01:   count <= count - CNT_B'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= {push_index, push_pred, push_alt_pc};
  end

  assign {head_index, head_pred, head_alt_pc} = mem[head];
  assign full  = (count == CNT_B'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order predicted-branch tracker driving the gshare update port
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int IDX_W = $bits(pht_idx_t),
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = BRQ_DEPTH,
  parameter int CNT_W = CNT_W_DEF,
  localparam int CNT_B = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [IDX_W-1:0] alloc_index,
  input  logic             alloc_pred,
  input  logic [PC_W-1:0]  alloc_alt_pc,
  input  logic             resolve_valid,
  input  logic             resolve_take,
  input  logic             flush,
  output logic             pht_wen,
  output logic [IDX_W-1:0] pht_windex,
  output logic             pht_take,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             empty,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);
  logic [IDX_W-1:0] head_index;
  logic             head_pred;
  logic [PC_W-1:0]  head_alt_pc;
  logic [CNT_B-1:0] count;
  logic             full;
  logic             do_resolve;
  logic             clear;
  logic [redirect_width(PC_W)-1:0] redirect_now;

  assign do_resolve   = resolve_valid && !empty;
  assign redirect_now = {do_resolve && (resolve_take != head_pred), head_alt_pc};
  // The resolving branch is older than anything flushed, so it still completes.
  assign clear        = flush || redirect_now[PC_W];
  assign alloc_ready  = (count < CNT_B'(DEPTH));

  brq_ring #(.IDX_W(IDX_W), .PC_W(PC_W), .DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst         (rst),
    .push        (alloc_valid && !full),
    .push_index  (alloc_index),
    .push_pred   (alloc_pred),
    .push_alt_pc (alloc_alt_pc),
    .pop         (do_resolve),
    .clear       (clear),
    .head_index  (head_index),
    .head_pred   (head_pred),
    .head_alt_pc (head_alt_pc),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pht_wen       <= 1'b0;
      pht_windex    <= '0;
      pht_take      <= 1'b0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      pht_wen    <= do_resolve;
      mispredict <= redirect_now[PC_W];
      if (redirect_now[PC_W]) redirect_pc <= redirect_now[PC_W-1:0];
      if (do_resolve) begin
        pht_windex <= head_index;
        pht_take   <= resolve_take;
        if (stat_branches != '1) stat_branches <= stat_branches + CNT_W'(1);
        if (redirect_now[PC_W] && stat_mispred != '1) stat_mispred <= stat_mispred + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [7:0]  alloc_index = '0;
  logic        alloc_pred = 1'b0;
  logic [31:0] alloc_alt_pc = '0;
  logic        resolve_valid = 1'b0;
  logic        resolve_take = 1'b0;
  logic        flush = 1'b0;
  logic        pht_wen;
  logic [7:0]  pht_windex;
  logic        pht_take;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        empty;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int total = 0;
  int bad = 0;

  branch_resolve_queue dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_index   (alloc_index),
    .alloc_pred    (alloc_pred),
    .alloc_alt_pc  (alloc_alt_pc),
    .resolve_valid (resolve_valid),
    .resolve_take  (resolve_take),
    .flush         (flush),
    .pht_wen       (pht_wen),
    .pht_windex    (pht_windex),
    .pht_take      (pht_take),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .empty         (empty),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  idx;
    logic        pred;
    logic [31:0] alt;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_head;
  ent_t        m_new;
  logic        m_wen = 1'b0;
  logic [7:0]  m_windex = '0;
  logic        m_take = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_rpc = '0;
  logic [31:0] m_sb = '0;
  logic [31:0] m_sm = '0;
  logic        m_could_alloc;

  // Reference: a plain FIFO of outstanding branches, oldest at the front.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_wen = 1'b0; m_windex = '0; m_take = 1'b0;
      m_mis = 1'b0; m_rpc = '0; m_sb = '0; m_sm = '0;
    end else begin
      m_could_alloc = (mq.size() < 4);
      m_wen = resolve_valid && (mq.size() > 0);
      m_mis = 1'b0;
      if (m_wen) begin
        m_head   = mq.pop_front();
        m_windex = m_head.idx;
        m_take   = resolve_take;
        m_mis    = (resolve_take != m_head.pred);
        if (m_mis) m_rpc = m_head.alt;
        if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
        if (m_mis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
      end
      if (flush || m_mis) mq.delete();
      else if (alloc_valid && m_could_alloc) begin
        m_new.idx = alloc_index; m_new.pred = alloc_pred; m_new.alt = alloc_alt_pc;
        mq.push_back(m_new);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_alloc_ready", 64'(alloc_ready), 64'(mq.size() < 4));
    chk("m_empty", 64'(empty), 64'(mq.size() == 0));
    chk("m_pht_wen", 64'(pht_wen), 64'(m_wen));
    chk("m_mispredict", 64'(mispredict), 64'(m_mis));
    chk("m_stat_branches", 64'(stat_branches), 64'(m_sb));
    chk("m_stat_mispred", 64'(stat_mispred), 64'(m_sm));
    if (m_wen) begin
      chk("m_pht_windex", 64'(pht_windex), 64'(m_windex));
      chk("m_pht_take", 64'(pht_take), 64'(m_take));
    end
    if (m_mis) chk("m_redirect_pc", 64'(redirect_pc), 64'(m_rpc));
  end

  // Called at a falling edge; returns at the next falling edge with the result visible.
  task automatic cyc(input logic av, input logic [7:0] idx, input logic pr, input logic [31:0] alt,
                     input logic rv, input logic rt, input logic fl);
    alloc_valid = av; alloc_index = idx; alloc_pred = pr; alloc_alt_pc = alt;
    resolve_valid = rv; resolve_take = rt; flush = fl;
    @(negedge clk);
    alloc_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset mid-stream with a pending PHT pulse.
    for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 1, 32'h100 * i, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t1_pre_wen", 64'(pht_wen), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_ready", 64'(alloc_ready), 64'd1);
    chk("t1_wen", 64'(pht_wen), 64'd0);
    chk("t1_stat_b", 64'(stat_branches), 64'd0);
    chk("t1_stat_m", 64'(stat_mispred), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Correct prediction.
    cyc(1, 8'h5A, 1, 32'h1000_0010, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t2_wen", 64'(pht_wen), 64'd1);
    chk("t2_windex", 64'(pht_windex), 64'h5A);
    chk("t2_take", 64'(pht_take), 64'd1);
    chk("t2_mis", 64'(mispredict), 64'd0);
    chk("t2_stat_b", 64'(stat_branches), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t2_wen_drop", 64'(pht_wen), 64'd0);

    // Fill, overflow attempt, mispredict squash.
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h10 + i), 0, 32'h2000_0000 + 32'(4 * i), 0, 0, 0);
    chk("t3_full", 64'(alloc_ready), 64'd0);
    cyc(1, 8'h99, 0, 32'hDEAD_0000, 0, 0, 0);
    chk("t3_full2", 64'(alloc_ready), 64'd0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t3_mis", 64'(mispredict), 64'd1);
    chk("t3_rpc", 64'(redirect_pc), 64'h2000_0000);
    chk("t3_windex", 64'(pht_windex), 64'h10);
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_stat_m", 64'(stat_mispred), 64'd1);
    chk("t3_stat_b", 64'(stat_branches), 64'd2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t3_mis_pulse", 64'(mispredict), 64'd0);

    // Wrap-around with overlapping alloc and resolve.
    do_reset();
    cyc(1, 8'h30, 0, 32'h3000, 0, 0, 0);
    for (int i = 1; i < 10; i++) begin
      cyc(1, 8'(8'h30 + i), 1'(i), 32'h3000 + 32'(i), 1, 1'(i - 1), 0);
      chk("t4_windex", 64'(pht_windex), 64'(8'h30 + i - 1));
      chk("t4_mis", 64'(mispredict), 64'd0);
    end
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t4_last_windex", 64'(pht_windex), 64'h39);
    chk("t4_stat_b", 64'(stat_branches), 64'd10);
    chk("t4_stat_m", 64'(stat_mispred), 64'd0);

    // Full queue: simultaneous alloc and correct resolve must not accept the alloc.
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h60 + i), 1, 32'h6000, 0, 0, 0);
    cyc(1, 8'h88, 1, 32'h8800, 1, 1, 0);
    chk("t7_windex", 64'(pht_windex), 64'h60);
    chk("t7_ready", 64'(alloc_ready), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t7_last", 64'(pht_windex), 64'h63);
    chk("t7_empty", 64'(empty), 64'd1);

    // Flush with a concurrent correct resolve and alloc.
    cyc(1, 8'h40, 0, 32'h4000, 0, 0, 0);
    cyc(1, 8'h41, 1, 32'h4100, 0, 0, 0);
    cyc(1, 8'h77, 1, 32'h7700, 1, 0, 1);
    chk("t5_wen", 64'(pht_wen), 64'd1);
    chk("t5_windex", 64'(pht_windex), 64'h40);
    chk("t5_take", 64'(pht_take), 64'd0);
    chk("t5_mis", 64'(mispredict), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    chk("t5_stat_b", 64'(stat_branches), 64'd15);

    // Resolve on an empty queue.
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("t6_wen", 64'(pht_wen), 64'd0);
    chk("t6_stat_b", 64'(stat_branches), 64'd15);
    chk("t6_stat_m", 64'(stat_mispred), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracking queue for predicted conditional branches, between fetch-side prediction and the gshare predictor's update port.
- At prediction time, fetch pushes the gshare read index, the predicted direction and the alternate-path PC.
- When execute resolves the oldest branch, the block:
  - drives the gshare write port (wen/windex/take), registered;
  - compares actual vs predicted direction;
  - on mismatch, raises a one-cycle mispredict with the redirect PC and drops all younger entries.

Parameters:
- IDX_W, 8, gshare index width; equals GHR length.
- PC_W, 32, PC width.
- DEPTH, 4, queue entries; power of two, ≥2.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  a predicted branch enters the queue.
- alloc_ready  out  1  the queue can accept; equals (count < DEPTH).
- alloc_index  in  IDX_W  gshare rindex used for the prediction.
- alloc_pred  in  1  predicted direction (1 = taken).
- alloc_alt_pc  in  PC_W  PC of the path not predicted (fall-through if predicted taken, target if not).
- resolve_valid  in  1  execute resolved the oldest outstanding branch.
- resolve_take  in  1  actual direction.
- flush  in  1  external pipeline flush (exception/eret); empties the queue.
- pht_wen  out  1  gshare write enable.
- pht_windex  out  IDX_W  gshare write index.
- pht_take  out  1  gshare actual direction.
- mispredict  out  1  one-cycle pulse on direction mismatch.
- redirect_pc  out  PC_W  alt PC of the mispredicted branch; valid only while mispredict=1.
- empty  out  1  count == 0.
- stat_branches  out  CNT_W  resolved branches.
- stat_mispred  out  CNT_W  mispredicted branches.

Behaviour:
- **Storage:** circular buffer of DEPTH entries {index, pred, alt_pc}.
  - head and tail are log2(DEPTH)-bit pointers that wrap naturally.
  - count is 0..DEPTH, log2(DEPTH)+1 bits.
- **Reset (async, rst=1):**
  - head, tail, count = 0.
  - pht_wen, pht_take, mispredict = 0; pht_windex = 0; redirect_pc = 0.
  - Stats = 0.
  - As a consequence, alloc_ready=1 and empty=1.
  - Reset asserted mid-operation discards all entries and any pending output pulse.
- **Alloc:** when alloc_valid && alloc_ready, the entry is written at tail and tail increments.
  - alloc_valid while full is ignored; nothing is written.
- **Resolve:** acts only when resolve_valid && count != 0 at the clock edge.
  - On the next cycle, a one-cycle pulse: pht_wen=1, pht_windex=head.index, pht_take=resolve_take.
  - mispredict = (resolve_take != head.pred); redirect_pc = head.alt_pc when mispredict is set.
  - head increments.
  - stat_branches++; stat_mispred++ if mispredict. Both saturate at all-ones.
  - resolve_valid when the queue is empty is ignored: no write, no stats.
- **Latency:** resolve to pht_wen/mispredict is exactly 1 cycle.
- **Mispredict squash:** in the resolving cycle, head/tail/count are set to empty, dropping all younger entries.
  - A same-cycle alloc is also dropped, because it is younger.
- **Flush:**
  - Empties the queue and drops a same-cycle alloc.
  - A same-cycle valid resolve is still performed in full: PHT write, stats and mispredict pulse. The resolving branch is older than the flushing instruction.
- **Simultaneous alloc + correct resolve:**
  - count is unchanged.
  - Alloc is gated by the pre-edge alloc_ready, so a full queue does not accept in that cycle.
- **Back-to-back resolves:** one per cycle is supported; pht_wen may stay high on consecutive cycles.

Decomposition:
- Shared header holds:
  - GHR_LEN / IDX_W default;
  - PHT_NUMS;
  - BRQ_DEPTH;
  - the entry field widths;
  - the mispredict/redirect bundle width.
- The storage is a natural sub-module: brq_ring, a DEPTH×(IDX_W+1+PC_W) register ring with push/pop/clear and count/full/empty outputs.
- The top level keeps the compare, output registers and stats.

Test Plan:
1. **Reset values:** assert rst mid-stream with 3 entries -> immediately after reset: empty=1, alloc_ready=1, pht_wen=0, stats=0.
2. **Correct prediction:** alloc {idx=0x5A, pred=1, alt=0x1000_0010}, then resolve take=1 -> next cycle: pht_wen=1, windex=0x5A, take=1, mispredict=0, stat_branches=1.
3. **Mispredict squash:** fill 4 entries (alloc_ready→0, 5th alloc ignored); resolve head (pred=0) take=1 -> mispredict=1, redirect_pc=head alt, empty=1 next cycle, stat_mispred=1.
4. **Wrap-around:** 10 alloc/resolve pairs with DEPTH=4, all correct -> windex sequence matches alloc order, stat_branches=10, no mispredict.
5. **Flush with concurrent resolve:** 2 entries queued; same cycle flush=1 and resolve take=0 with head pred=0 -> pht_wen=1, mispredict=0, queue empty, same-cycle alloc dropped.
6. **Resolve on empty queue:** resolve_valid=1 with count=0 -> pht_wen stays 0, stats unchanged.
